// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C command path (arbiter and write engine).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_pkg;

    // Arbiter phases: pick a requester, present its word to the engine, wait for the bus to finish.
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        SEND      = 2'b01,
        WAIT_DONE = 2'b10
    } arb_state_t;

    // Geometry of an I2C write as seen by the engine.
    localparam int I2C_ADDR_WIDTH = 7;
    localparam int I2C_DATA_WIDTH = 8;

endpackage

// File: rtl/axis_i2c_arbiter_if.sv
// Bundle of requester-side and engine-side AXIS signals around the I2C arbiter.
// Latency: n/a (wiring only).
// Backpressure: s_tready per requester, m_tready from the engine.
interface axis_i2c_arbiter_if #(
    parameter int NUM_REQ         = 4,
    parameter int AXIS_DATA_WIDTH = 16
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                 s_tvalid;
    logic [NUM_REQ*AXIS_DATA_WIDTH-1:0] s_tdata;
    logic [NUM_REQ-1:0]                 s_tready;
    logic                               m_tvalid;
    logic [AXIS_DATA_WIDTH-1:0]         m_tdata;
    logic                               m_tready;
    logic                               i2c_busy;
    logic [IDX_W-1:0]                   grant_id;
    logic                               done;
    logic                               timeout;

    // Arbiter view: drives the engine port and the per-requester readies.
    modport master (
        input  s_tvalid, s_tdata, m_tready, i2c_busy,
        output s_tready, m_tvalid, m_tdata, grant_id, done, timeout
    );

    // Surrounding system view: requesters plus the engine.
    modport slave (
        output s_tvalid, s_tdata, m_tready, i2c_busy,
        input  s_tready, m_tvalid, m_tdata, grant_id, done, timeout
    );
endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first set req bit searching upward from last+1, wrapping at NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; any=0 means gnt_idx is don't-care (driven 0).
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       any
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Walk offsets 1..NUM_REQ from the last winner; the first hit wins, so last itself is checked last.
    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            sum = {1'b0, last} + (IDX_W+1)'(off);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                gnt_idx = cand;
                found   = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/axis_i2c_arbiter.sv
// Shares one AXIS I2C write engine between NUM_REQ requesters, round-robin, one word per grant.
// Latency: accept in cycle 0, m_tvalid from cycle 1; done/timeout one cycle after the deciding WAIT_DONE cycle.
// Backpressure: holds m_tvalid/m_tdata until m_tready; no s_tready while a transfer is outstanding.
module axis_i2c_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int AXIS_DATA_WIDTH = 16,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                   clk,
    input  logic                   arstn,
    axis_i2c_arbiter_if.master     bus
);
    import i2c_pkg::*;

    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    arb_state_t                 state_q,      state_d;
    logic                       m_tvalid_q,   m_tvalid_d;
    logic [AXIS_DATA_WIDTH-1:0] m_tdata_q,    m_tdata_d;
    logic [IDX_W-1:0]           grant_id_q,   grant_id_d;
    logic [IDX_W-1:0]           last_grant_q, last_grant_d;
    logic [CNT_W-1:0]           cnt_q,        cnt_d;
    logic                       done_q,       done_d;
    logic                       timeout_q,    timeout_d;
    logic [NUM_REQ-1:0]         s_tready_c;

    logic [IDX_W-1:0]           win_idx;
    logic                       win_any;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req     (bus.s_tvalid),
        .last    (last_grant_q),
        .gnt_idx (win_idx),
        .any     (win_any)
    );

    // Next-state logic: accept in IDLE, hand the word to the engine, then wait for busy to drop or the timer.
    always_comb begin
        state_d      = state_q;
        m_tvalid_d   = m_tvalid_q;
        m_tdata_d    = m_tdata_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        timeout_d    = 1'b0;
        s_tready_c   = '0;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    s_tready_c[win_idx] = 1'b1;
                    m_tdata_d  = bus.s_tdata[int'(win_idx)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
                    grant_id_d = win_idx;
                    m_tvalid_d = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                // Busy is not looked at here: the engine only leaves IDLE on this handshake edge.
                if (bus.m_tready) begin
                    m_tvalid_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                // A finished bus wins over an expiring timer in the same cycle.
                if (!bus.i2c_busy) begin
                    done_d       = 1'b1;
                    last_grant_d = grant_id_q;
                    state_d      = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d    = 1'b1;
                    last_grant_d = grant_id_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset leaves requester 0 first in line and drops any in-flight word.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q      <= IDLE;
            m_tvalid_q   <= 1'b0;
            m_tdata_q    <= '0;
            grant_id_q   <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            cnt_q        <= '0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tdata_q    <= m_tdata_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.s_tready = s_tready_c;
    assign bus.m_tvalid = m_tvalid_q;
    assign bus.m_tdata  = m_tdata_q;
    assign bus.grant_id = grant_id_q;
    assign bus.done     = done_q;
    assign bus.timeout  = timeout_q;

endmodule

// File: doc/axis_i2c_arbiter.md
# axis_i2c_arbiter

Round-robin arbiter that shares one AXI-Stream I2C write engine between `NUM_REQ` independent requesters. It accepts one transfer word from the winning requester, forwards it to the engine's AXIS slave port, and holds the grant until the engine reports the bus transaction finished or a timeout expires. It sits between the register/command sources and the I2C engine, and is the only block that drives the engine's `s_axis` port.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..16.
- `AXIS_DATA_WIDTH`, 16: transfer word width; matches the engine's `AXIS_DATA_WIDTH`.
- `TIMEOUT_CYCLES`, 4096: maximum `clk` cycles spent in WAIT_DONE before abort; must be ≥ 2.

Ports (one clock `clk`; reset `arstn` is asynchronous, active-low):
- `clk`  in  1  system clock; every flop uses its rising edge.
- `arstn`  in  1  asynchronous active-low reset.
- `s_tvalid`  in  NUM_REQ  per-requester valid.
- `s_tdata`  in  NUM_REQ×AXIS_DATA_WIDTH  per-requester data; requester i uses slice i.
- `s_tready`  out  NUM_REQ  per-requester ready; at most one bit high.
- `m_tvalid`  out  1  to engine `s_axis.tvalid`.
- `m_tdata`  out  AXIS_DATA_WIDTH  to engine `s_axis.tdata`.
- `m_tready`  in  1  from engine `s_axis.tready`.
- `i2c_busy`  in  1  high while the engine is outside its IDLE state.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current or most recent grant.
- `done`  out  1  one-cycle pulse when a transfer completes normally.
- `timeout`  out  1  one-cycle pulse when a transfer is aborted.

## Operation
- States: IDLE, SEND, WAIT_DONE.
- IDLE: the winner is the first asserted `s_tvalid` bit, searching upward from `last_grant+1` modulo NUM_REQ.
  - `s_tready[winner]` is asserted combinationally in the same cycle, only while `s_tvalid` is nonzero.
  - The accept cycle latches `s_tdata[winner]` into `m_tdata` and the winner into `grant_id`, sets `m_tvalid=1`, and moves to SEND.
- SEND: `m_tvalid` and `m_tdata` are held stable until `m_tready=1`. On that handshake, clear `m_tvalid`, clear the timeout counter, and move to WAIT_DONE.
- WAIT_DONE: all `s_tready` are low. The counter increments every cycle.
  - If `i2c_busy=0`: pulse `done`, set `last_grant=grant_id`, return to IDLE.
  - Else, if counter reaches `TIMEOUT_CYCLES-1`: pulse `timeout`, set `last_grant=grant_id`, return to IDLE.
  - If both conditions hold in the same cycle, `done` takes priority.
- `i2c_busy` is not checked in the handshake cycle itself, because the engine leaves IDLE on the edge that samples `m_tready`.
- Requesters that lose arbitration keep `s_tvalid` asserted. No request is dropped or reordered within a requester.
- A requester may drop `s_tvalid` while not granted.
- Reset at any point, including mid-SEND or mid-WAIT_DONE:
  - state IDLE
  - `m_tvalid=0`, `m_tdata=0`, `grant_id=0`
  - `last_grant=NUM_REQ-1`, so requester 0 has priority first
  - `done=0`, `timeout=0`, counter 0
  - `s_tready` all 0 (combinational from reset state and zero `s_tvalid`)
  - An in-flight word is lost; no `done` pulse.

## Timing
- Accept, cycle 0: `s_tvalid[i]` high in IDLE gives `s_tready[i]` high in the same cycle. `m_tvalid` is high from cycle 1.
- Engine handshake at cycle h gives `m_tvalid` low at h+1.
- `i2c_busy` first sampled low at cycle k ≥ h+1 gives `done` high for the single cycle k+1 and state IDLE at k+1. The next accept can occur at k+1.
- Timeout: `timeout` pulses at h+1+TIMEOUT_CYCLES when `i2c_busy` stays high.
- Minimum spacing between accepts: 3 cycles (engine ready immediately, busy already low).
- Counter width is $clog2(TIMEOUT_CYCLES). It saturates and never wraps.

## Structure
- Shared package `i2c_pkg` holds:
  - `arb_state_t` enum (IDLE=2'b00, SEND=2'b01, WAIT_DONE=2'b10)
  - `I2C_ADDR_WIDTH` and `I2C_DATA_WIDTH` constants shared with the engine.
- One sub-module, `rr_pick`: a purely combinational round-robin priority picker. Inputs `req[NUM_REQ]` and `last`; outputs `gnt_idx` and `any`. It is reused by future arbiters.
- The top holds the FSM, data register, timeout counter and pulse outputs.

## Test plan
- Reset release with `s_tvalid=0`: all outputs 0 and `grant_id=0` for 20 cycles.
- Single request: requester 2 sends 16'hA55A with the engine model holding `m_tready` after 3 cycles and busy for 40 cycles. Expected: `s_tready[2]` is a one-cycle pulse, `m_tdata=16'hA55A` stable while `m_tvalid` is high, one `done` pulse, `grant_id=2`.
- Contention: all 4 requesters valid continuously for 8 transfers. Expected grant order 0,1,2,3,0,1,2,3, and no `s_tready` bit high outside IDLE.
- Timeout: `TIMEOUT_CYCLES=8` and `i2c_busy` stuck at 1 after the handshake. Expected: `timeout` pulses exactly 8 cycles after WAIT_DONE entry, no `done`, and the next requester is served.
- Reset mid-WAIT_DONE: `arstn` low for 2 cycles. Expected: all outputs return to reset values immediately, and requester 0 wins the first post-reset arbitration.
- Busy already low at the first WAIT_DONE cycle: `done` at h+2, and back-to-back accept spacing is exactly 3 cycles.
